// File: rtl/spi_controller.sv
// SPI mode-0 write controller: one 16-bit MSB-first frame {rw, addr[6:0], data[7:0]} per request.
// Optional address range check enabled by defining SPI_CTRL_ADDR_CHECK_EN.
`timescale 1ns/1ps
module spi_controller #(
   parameter int unsigned CLK_DIV    = 4,
   parameter int unsigned GAP_CYCLES = 8,
   parameter int unsigned MAX_ADDR   = 4
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       req_valid_i,
   output logic       req_ready_o,
   input  logic       req_rw_i,
   input  logic [6:0] req_addr_i,
   input  logic [7:0] req_data_i,
   output logic       busy_o,
   output logic       done_o,
   output logic       err_o,
   output logic       ncs_o,
   output logic       sclk_o,
   output logic       copi_o
);

   typedef enum logic [2:0] {StIdle, StLow, StHigh, StHold, StGap} state_e;

   localparam logic [7:0] DivLoad = 8'(CLK_DIV - 1);
   localparam logic [7:0] GapLoad = 8'(GAP_CYCLES - 1);

   state_e      state_q;
   logic [7:0]  div_q;
   logic [4:0]  bit_cnt_q;
   logic [15:0] shift_q;
   logic        ncs_q;
   logic        sclk_q;
   logic        done_q;
   logic        err_q;
   logic        addr_bad;

`ifdef SPI_CTRL_ADDR_CHECK_EN
   assign addr_bad = ({25'd0, req_addr_i} > MAX_ADDR);
`else
   assign addr_bad = 1'b0;
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= StIdle;
         div_q     <= 8'd0;
         bit_cnt_q <= 5'd0;
         shift_q   <= 16'd0;
         ncs_q     <= 1'b1;
         sclk_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (req_valid_i) begin
                  if (addr_bad) begin
                     err_q <= 1'b1;
                  end else begin
                     shift_q   <= {req_rw_i, req_addr_i, req_data_i};
                     bit_cnt_q <= 5'd0;
                     div_q     <= DivLoad;
                     ncs_q     <= 1'b0;
                     sclk_q    <= 1'b0;
                     state_q   <= StLow;
                  end
               end
            end
            StLow: begin
               if (div_q == 8'd0) begin
                  div_q   <= DivLoad;
                  sclk_q  <= 1'b1;
                  state_q <= StHigh;
               end else begin
                  div_q <= div_q - 8'd1;
               end
            end
            StHigh: begin
               if (div_q == 8'd0) begin
                  div_q     <= DivLoad;
                  sclk_q    <= 1'b0;
                  bit_cnt_q <= bit_cnt_q + 5'd1;
                  // Last bit is not shifted out so COPI keeps it through HOLD.
                  if (bit_cnt_q == 5'd15) begin
                     state_q <= StHold;
                  end else begin
                     shift_q <= {shift_q[14:0], 1'b0};
                     state_q <= StLow;
                  end
               end else begin
                  div_q <= div_q - 8'd1;
               end
            end
            StHold: begin
               if (div_q == 8'd0) begin
                  div_q   <= GapLoad;
                  ncs_q   <= 1'b1;
                  done_q  <= 1'b1;
                  shift_q <= 16'd0;
                  state_q <= StGap;
               end else begin
                  div_q <= div_q - 8'd1;
               end
            end
            StGap: begin
               if (div_q == 8'd0) begin
                  state_q <= StIdle;
               end else begin
                  div_q <= div_q - 8'd1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign req_ready_o = (state_q == StIdle);
   assign busy_o      = (state_q != StIdle);
   assign done_o      = done_q;
   assign err_o       = err_q;
   assign ncs_o       = ncs_q;
   assign sclk_o      = sclk_q;
   assign copi_o      = shift_q[15];

endmodule

// File: doc/spi_controller.md
Name: spi_controller

Overview:
SPI mode-0 write controller. It drives the nCS/SCLK/COPI lines of the register-file SPI peripheral from a local valid/ready request port. Each request becomes one 16-bit frame, MSB first: rw bit, 7-bit address, 8-bit data. The block is used by bring-up logic and test harnesses to program the output-enable, PWM-enable and duty-cycle registers across the SPI pins.

Parameters:
CLK_DIV, 4, SCLK half-period in clk cycles; legal range 3..255 so the peripheral's 2-flop synchronizers plus edge detect see every level.
GAP_CYCLES, 8, minimum nCS-high clk cycles between frames; lets the peripheral detect the nCS rising edge and commit; legal 4..255.
MAX_ADDR, 4, highest valid register address (used only by the optional feature).

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  controller idle and able to accept; high exactly in IDLE
req_rw  input  1  frame bit 15 (1 = write)
req_addr  input  7  frame bits 14:8
req_data  input  8  frame bits 7:0
busy  output  1  high from accept until return to IDLE
done  output  1  one-cycle pulse on the cycle nCS_out returns high after a transmitted frame
err  output  1  one-cycle pulse on a rejected request (optional feature; 0 otherwise)
nCS_out  output  1  chip select, active low
SCLK_out  output  1  serial clock, idle low
COPI_out  output  1  serial data to the peripheral

Behaviour:
- Single clock domain. Reset is asynchronous and active-low on rst_n.
- Reset values: nCS_out=1, SCLK_out=0, COPI_out=0, busy=0, done=0, err=0, state=IDLE, so req_ready=1.
- Reset asserted mid-frame aborts the frame immediately. The lines return to the idle values above. No done pulse.
- Accept: req_valid && req_ready sampled at a clk edge. The frame {req_rw, req_addr, req_data} is latched into a 16-bit shift register. Request inputs are ignored at all other times.
- State machine: IDLE -> LOW -> HIGH -> (LOW ... ) -> HOLD -> GAP -> IDLE.
- IDLE: nCS_out=1, SCLK_out=0, busy=0.
- LOW: entered the cycle after accept. nCS_out=0, SCLK_out=0, COPI_out = current MSB. Lasts CLK_DIV cycles.
- HIGH: SCLK_out=1, COPI_out stable, lasts CLK_DIV cycles.
  - At the end of HIGH the bit counter increments and the shift register shifts left. COPI therefore changes only on SCLK falling edges.
  - If 16 bits are complete, go to HOLD; otherwise go to LOW.
- HOLD: SCLK_out=0, nCS_out=0, COPI_out holds the last bit, lasts CLK_DIV cycles. Then nCS_out=1 and done pulses for 1 cycle.
- GAP: nCS_out=1, lasts GAP_CYCLES cycles, then IDLE.
- Timing:
  - nCS_out stays low for exactly 33*CLK_DIV cycles.
  - 16 SCLK rising edges per frame; the first occurs CLK_DIV cycles after nCS_out falls.
  - Accept-to-accept minimum is 1 + 33*CLK_DIV + GAP_CYCLES cycles.
- req_rw=0 frames are transmitted unchanged; the peripheral discards them.
- Back-to-back: req_valid held high is accepted again on the first IDLE cycle after GAP.
- Counters: 5-bit bit counter (0..16, no wrap), 8-bit divider counter that reloads on every state change.

Optional Feature:
SPI_CTRL_ADDR_CHECK_EN
- Defined: a request with req_addr > MAX_ADDR is still accepted (one handshake). The block stays in IDLE: no nCS activity, no done. err pulses the cycle after accept, and req_ready stays 1.
- Undefined: every address is transmitted, and err is tied to 0.

Test Plan:
- Reset, then request rw=1 addr=0x00 data=0xA5 with CLK_DIV=4 -> nCS low 132 cycles, 16 SCLK rises, COPI sampled at rises = 1,0000000,10100101; done 1 cycle as nCS rises; peripheral en_reg_out_7_0=0xA5.
- Back-to-back writes addr=0x04 data=0x80 then addr=0x02 data=0xFF, req_valid held -> second accept exactly GAP_CYCLES+1 cycles after the first nCS rise; peripheral pwm_duty_cycle=0x80, en_reg_pwm_7_0=0xFF.
- rw=0 addr=0x01 data=0x3C -> full 16-bit frame on the wire; peripheral en_reg_out_15_8 unchanged (0x00).
- rst_n low at the 7th SCLK rise -> nCS=1, SCLK=0, COPI=0 asynchronously; no done; req_ready=1 once reset is released; peripheral registers unchanged.
- req_data/req_addr changed while busy -> transmitted bits match the values latched at accept.
- With SPI_CTRL_ADDR_CHECK_EN, addr=0x05 -> err pulse, nCS stays 1, req_ready stays 1. Without the macro, the frame is transmitted and err=0.
